vector_arb: RTL
===============

Name: vector_arb

Overview:
Two-requester arbiter and sequencer for the shared 4-bit/5-bit slice/concat datapath.
- Each requester presents operands plus an op code over a valid/ready handshake.
- The arbiter grants one requester per cycle and drives the shared slice unit.
- The 5-bit result is registered into a small output FIFO, tagged with the requester ID.
- Sits between producer blocks and any consumer that needs truncated, extended, mid-sliced or concatenated fields.

Parameters:
OUT_DEPTH, 2, output FIFO depth; power of 2, range 2..8.
PRIO_FIXED, 0, 0 = round-robin; 1 = requester 0 always wins.

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
r0_valid  in  1  requester 0 request
r0_ready  out  1  requester 0 accepted this cycle
r0_op  in  2  requester 0 op code
r0_i0  in  4  requester 0 operand I0
r0_i1  in  5  requester 0 operand I1
r1_valid/r1_ready/r1_op/r1_i0/r1_i1  same as r0_*  requester 1
o_valid  out  1  FIFO head valid
o_ready  in  1  consumer pops head when o_valid&&o_ready
o_data  out  5  result
o_tag  out  1  requester that issued the result
o_op  out  2  op code that produced the result
o_count  out  clog2(OUT_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst=1): FIFO empty; o_valid=0, o_data=0, o_tag=0, o_op=0, o_count=0; rr pointer last=1, so r0 is preferred first; r0_ready=r1_ready=0 while rst high.
- Slice ops:
  - 0 TRUNC: {2'b0,I0[2:0]}
  - 1 ZEXT: {1'b0,I0}
  - 2 MID: {2'b0,I1[3:1]}
  - 3 CAT: {I0[2:0],I1[3:2]}
- Grant conditions:
  - Evaluated combinationally each cycle; a grant is issued only when o_count<OUT_DEPTH.
  - At full, no grant is issued even if a pop occurs the same cycle; this keeps the pop off the ready path.
  - At most one rN_ready is high. rN_ready=1 implies rN_valid=1.
- Round-robin (PRIO_FIXED=0):
  - With both valid, grant the requester other than last.
  - With one valid, grant it.
  - last updates only on an actual grant.
- Fixed priority (PRIO_FIXED=1): r0 wins whenever r0_valid; last is unused.
- Latency:
  - A request accepted at edge N is written to the FIFO at edge N.
  - If the FIFO was empty, o_valid=1 with that result in the cycle after N.
  - No combinational path from request inputs to o_*.
- FIFO:
  - Circular buffer with rd/wr pointers, wrapping at OUT_DEPTH.
  - Push+pop in the same cycle: count unchanged, order preserved.
  - Pop when empty is ignored.
  - o_data/o_tag/o_op hold their last values while o_valid=0 and o_ready=0.
- Requester hold rule: the requester must keep valid/operands stable until ready. A dropped valid before grant is legal and loses no state.
- Reset mid-operation: FIFO contents discarded, pointers and last reset immediately. No result for an in-flight grant appears after reset.

Optional Feature:
VECTOR_ARB_STATS_EN:
- Defined:
  - Adds ports stat_clr (in 1), stat_g0 (out 16), stat_g1 (out 16).
  - Per-requester grant counters that saturate at 16'hFFFF.
  - Reset to 0 on rst or stat_clr; stat_clr wins over an increment in the same cycle.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package vector_pkg:
  - op-code enum OP_TRUNC=0, OP_ZEXT=1, OP_MID=2, OP_CAT=3
  - constants I0_W=4, I1_W=5, O_W=5
  - FIFO entry struct {data, tag, op}
- Sub-module vector_slice: combinational op/i0/i1 -> 5-bit result. Arbiter, FIFO and counters stay in vector_arb.

Test Plan:
- Ops decode:
  - Stimulus: r0 only, i0=4'b1011, i1=5'b01110, ops 0..3 in sequence.
  - Response: o_data 00011, 01011, 00111, 01111, all with o_tag=0, one cycle after each grant.
- Round-robin:
  - Stimulus: both valid continuously, o_ready=1.
  - Response: grants r0,r1,r0,r1; o_tag alternates 0,1,0,1.
- Fixed priority:
  - Stimulus: PRIO_FIXED=1, both valid.
  - Response: r0 granted every cycle; r1_ready stays 0.
- Backpressure:
  - Stimulus: o_ready=0, 3 requests with OUT_DEPTH=2.
  - Response: 2 accepted, o_count=2, third requester ready=0.
  - Then: o_ready=1 for 1 cycle -> count 1, third accepted the next cycle.
- Simultaneous push/pop:
  - Stimulus: count=1, grant plus pop in the same cycle.
  - Response: count stays 1; FIFO order preserved.
- Async reset mid-stream:
  - Stimulus: rst pulsed between edges with count=2.
  - Response: o_valid=0 and o_count=0 immediately; the first grant after release goes to r0.
  - With VECTOR_ARB_STATS_EN: stat_g0/stat_g1 = 0 after reset; 70000 r0 grants saturate stat_g0 at 65535.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared types and widths for the vector_arb slice/concat datapath.
package vector_pkg;

   localparam int I0_W = 4;
   localparam int I1_W = 5;
   localparam int O_W  = 5;

   typedef enum logic [1:0] {
      OP_TRUNC = 2'd0,
      OP_ZEXT  = 2'd1,
      OP_MID   = 2'd2,
      OP_CAT   = 2'd3
   } op_e;

   typedef struct packed {
      logic [O_W-1:0] data;
      logic           tag;
      op_e            op;
   } fifo_entry_t;

endpackage

// File: rtl/vector_slice.sv
// Combinational slice unit: truncate, zero-extend, mid-slice or concatenate
// the two operands into a 5-bit result.
module vector_slice
   import vector_pkg::*;
(
   input  logic [1:0]      op,
   input  logic [I0_W-1:0] i0,
   input  logic [I1_W-1:0] i1,
   output logic [O_W-1:0]  result
);

   always_comb begin
      result = '0;
      case (op_e'(op))
         OP_TRUNC: result = {2'b00, i0[2:0]};
         OP_ZEXT:  result = {1'b0, i0};
         OP_MID:   result = {2'b00, i1[3:1]};
         OP_CAT:   result = {i0[2:0], i1[3:2]};
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/vector_arb.sv
// Two-requester arbiter feeding the shared slice unit and a tagged result FIFO.
// Optional grant statistics are built when VECTOR_ARB_STATS_EN is defined.
module vector_arb
   import vector_pkg::*;
#(
   parameter int OUT_DEPTH  = 2,
   parameter int PRIO_FIXED = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         r0_valid,
   output logic                         r0_ready,
   input  logic [1:0]                   r0_op,
   input  logic [I0_W-1:0]              r0_i0,
   input  logic [I1_W-1:0]              r0_i1,
   input  logic                         r1_valid,
   output logic                         r1_ready,
   input  logic [1:0]                   r1_op,
   input  logic [I0_W-1:0]              r1_i0,
   input  logic [I1_W-1:0]              r1_i1,
   output logic                         o_valid,
   input  logic                         o_ready,
   output logic [O_W-1:0]               o_data,
   output logic                         o_tag,
   output logic [1:0]                   o_op,
`ifdef VECTOR_ARB_STATS_EN
   input  logic                         stat_clr,
   output logic [15:0]                  stat_g0,
   output logic [15:0]                  stat_g1,
`endif
   output logic [$clog2(OUT_DEPTH):0]   o_count
);

   localparam int AW = $clog2(OUT_DEPTH);

   logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
   logic [AW:0]   count_reg;
   logic          last_reg;
   fifo_entry_t   hold_reg;
   fifo_entry_t   mem [OUT_DEPTH];
   fifo_entry_t   head;

   logic [1:0]      gnt;
   logic            full, push, pop, sel;
   logic [1:0]      op_sel;
   logic [I0_W-1:0] i0_sel;
   logic [I1_W-1:0] i1_sel;
   logic [O_W-1:0]  slice_res;

   // Full is judged on the registered count only, so a same-cycle pop never frees a slot.
   assign full = (count_reg == (AW+1)'(OUT_DEPTH));

   always_comb begin
      gnt = 2'b00;
      if (!rst && !full) begin
         if (PRIO_FIXED != 0) begin
            if (r0_valid)      gnt = 2'b01;
            else if (r1_valid) gnt = 2'b10;
         end else if (r0_valid && r1_valid) begin
            gnt = last_reg ? 2'b01 : 2'b10;
         end else begin
            gnt = {r1_valid, r0_valid};
         end
      end
   end

   assign r0_ready = gnt[0];
   assign r1_ready = gnt[1];
   assign push     = |gnt;
   assign sel      = gnt[1];
   assign pop      = o_valid && o_ready;
   assign op_sel   = sel ? r1_op : r0_op;
   assign i0_sel   = sel ? r1_i0 : r0_i0;
   assign i1_sel   = sel ? r1_i1 : r0_i1;

   vector_slice u_slice (
      .op     (op_sel),
      .i0     (i0_sel),
      .i1     (i1_sel),
      .result (slice_res)
   );

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= '{data: slice_res, tag: sel, op: op_e'(op_sel)};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         last_reg   <= 1'b1;
         hold_reg   <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            hold_reg   <= mem[rd_ptr_reg];
         end
         if (push && !pop)      count_reg <= count_reg + 1'b1;
         else if (!push && pop) count_reg <= count_reg - 1'b1;
         if (push && PRIO_FIXED == 0) last_reg <= sel;
      end
   end

   // While empty, keep presenting the most recently popped entry.
   assign o_valid = (count_reg != '0);
   assign head    = o_valid ? mem[rd_ptr_reg] : hold_reg;
   assign o_data  = head.data;
   assign o_tag   = head.tag;
   assign o_op    = head.op;
   assign o_count = count_reg;

`ifdef VECTOR_ARB_STATS_EN
   logic [15:0] stat_cnt [2];

   for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      logic [15:0] cnt_reg;

      always_ff @(posedge clk or posedge rst) begin
         if (rst)                                    cnt_reg <= '0;
         else if (stat_clr)                          cnt_reg <= '0;
         else if (gnt[gi] && cnt_reg != 16'hFFFF)    cnt_reg <= cnt_reg + 1'b1;
      end

      assign stat_cnt[gi] = cnt_reg;
   end

   assign stat_g0 = stat_cnt[0];
   assign stat_g1 = stat_cnt[1];
`endif

endmodule
